// File: rtl/l3_core_ep_if.sv
// L3 core endpoint bus: command, buffer-access and response signals.
// master = channel side, slave = core endpoint.
interface l3_core_ep_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              cmd_en;
    logic [7:0]        cmd_op;
    logic [15:0]       cmd_extend;
    logic [15:0]       wr_size;
    logic              cmd_rdy;
    logic              wr_open;
    logic              buf_wr_en;
    logic              rd_open;
    logic              buf_rd_en;
    logic              wb_rd_en;
    logic [ADDR_W-1:0] wb_rd_addr;
    logic [DATA_W-1:0] wb_rd_d;
    logic              rb_wr_en;
    logic [ADDR_W-1:0] rb_wr_addr;
    logic [DATA_W-1:0] rb_wr_d;
    logic              resp_rdy;
    logic              resp_done;
    logic [1:0]        resp_err;
    logic [3:0]        resp_res;
    logic [31:0]       chk_sum;

    modport master (
        output cmd_en, cmd_op, cmd_extend, wr_size, buf_wr_en, buf_rd_en, wb_rd_d,
        input  cmd_rdy, wr_open, rd_open, wb_rd_en, wb_rd_addr, rb_wr_en, rb_wr_addr,
               rb_wr_d, resp_rdy, resp_done, resp_err, resp_res, chk_sum
    );

    modport slave (
        input  cmd_en, cmd_op, cmd_extend, wr_size, buf_wr_en, buf_rd_en, wb_rd_d,
        output cmd_rdy, wr_open, rd_open, wb_rd_en, wb_rd_addr, rb_wr_en, rb_wr_addr,
               rb_wr_d, resp_rdy, resp_done, resp_err, resp_res, chk_sum
    );
endinterface

// File: rtl/l3_core_ep.sv
// Core-side L3 endpoint: WRITE drains and checksums the write buffer, READ fills the read buffer.
// Optional watchdog on channel stalls: define L3_EP_TIMEOUT_EN.
module l3_core_ep #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_core,
    l3_core_ep_if.slave bus
);
    localparam logic [2:0]  S_IDLE   = 3'd0;
    localparam logic [2:0]  S_WFILL  = 3'd1;
    localparam logic [2:0]  S_WDRAIN = 3'd2;
    localparam logic [2:0]  S_RFILL  = 3'd3;
    localparam logic [2:0]  S_RDRAIN = 3'd4;
    localparam logic [2:0]  S_RESP   = 3'd5;

    localparam logic [7:0]  OP_WRITE = 8'h01;
    localparam logic [7:0]  OP_READ  = 8'h02;
    localparam logic [16:0] MAX_CNT  = 17'd1 << ADDR_W;

    localparam logic [1:0]  E_OK      = 2'b00;
    localparam logic [1:0]  E_OP      = 2'b01;
    localparam logic [1:0]  E_SIZE    = 2'b10;
    localparam logic [1:0]  E_TIMEOUT = 2'b11;

    function automatic logic [1:0] check_cmd(input logic [7:0] op, input logic [16:0] cnt);
        if (op != OP_WRITE && op != OP_READ) return E_OP;
        if (cnt == 17'd0 || cnt > MAX_CNT)   return E_SIZE;
        return E_OK;
    endfunction

    function automatic logic [DATA_W-1:0] fill_word(input logic [15:0] idx);
        logic [31:0] w;
        w = {idx, ~idx};
        return DATA_W'(w);
    endfunction

    logic [2:0]  state;
    logic [16:0] cnt;
    logic [16:0] n;
    logic [3:0]  op_res;
    logic        vld_p1;
    logic [31:0] chk_sum;
    logic        resp_done;
    logic [1:0]  resp_err;
    logic [3:0]  resp_res;

    logic        cmd_rdy;
    logic        accept;
    logic        strobe;
    logic        last_strobe;
    logic        wb_rd_en;
    logic [16:0] acc_cnt;
    logic [16:0] cnt_inc;
    logic [1:0]  acc_err;

`ifdef L3_EP_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wdog;
`endif

    // cmd_rdy is gated by rst_n so every output reads 0 while reset is held
    assign cmd_rdy     = rst_n && (state == S_IDLE);
    assign accept      = cmd_rdy && bus.cmd_en;
    assign acc_cnt     = (bus.cmd_op == OP_READ) ? {1'b0, bus.cmd_extend} : {1'b0, bus.wr_size};
    assign acc_err     = check_cmd(bus.cmd_op, acc_cnt);
    assign cnt_inc     = cnt + 17'd1;
    assign strobe      = (state == S_WFILL && bus.buf_wr_en) || (state == S_RDRAIN && bus.buf_rd_en);
    assign last_strobe = strobe && (cnt_inc == n);
    assign wb_rd_en    = (state == S_WDRAIN) && (cnt != n);

    assign bus.cmd_rdy    = cmd_rdy;
    assign bus.wr_open    = (state == S_WFILL);
    assign bus.rd_open    = (state == S_RDRAIN);
    assign bus.wb_rd_en   = wb_rd_en;
    assign bus.wb_rd_addr = cnt[ADDR_W-1:0];
    assign bus.rb_wr_en   = (state == S_RFILL);
    assign bus.rb_wr_addr = cnt[ADDR_W-1:0];
    assign bus.rb_wr_d    = (state == S_RFILL) ? fill_word(cnt[15:0]) : '0;
    assign bus.resp_rdy   = (state == S_RESP);
    assign bus.resp_done  = resp_done;
    assign bus.resp_err   = resp_err;
    assign bus.resp_res   = resp_res;
    assign bus.chk_sum    = chk_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            n         <= '0;
            op_res    <= '0;
            vld_p1    <= 1'b0;
            chk_sum   <= '0;
            resp_done <= 1'b0;
            resp_err  <= E_OK;
            resp_res  <= '0;
`ifdef L3_EP_TIMEOUT_EN
            wdog      <= '0;
`endif
        end else if (clr_core) begin
            state  <= S_IDLE;
            cnt    <= '0;
            vld_p1 <= 1'b0;
`ifdef L3_EP_TIMEOUT_EN
            wdog   <= '0;
`endif
        end else begin
            // p1: write-buffer data arrives one cycle after wb_rd_en
            vld_p1 <= wb_rd_en;
            if (vld_p1) chk_sum <= chk_sum + 32'(bus.wb_rd_d);
`ifdef L3_EP_TIMEOUT_EN
            // Zero outside the open states, so it restarts on every entry
            wdog <= (strobe || (state != S_WFILL && state != S_RDRAIN)) ? 16'd0 : wdog + 16'd1;
`endif
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_res    <= bus.cmd_op[3:0];
                        n         <= acc_cnt;
                        cnt       <= '0;
                        chk_sum   <= '0;
                        resp_done <= 1'b0;
                        resp_err  <= acc_err;
                        resp_res  <= '0;
                        if (acc_err != E_OK) begin
                            state    <= S_RESP;
                            resp_res <= bus.cmd_op[3:0];
                        end else if (bus.cmd_op == OP_WRITE) begin
                            state <= S_WFILL;
                        end else begin
                            state <= S_RFILL;
                        end
                    end
                end
                S_WFILL, S_RDRAIN: begin
                    if (strobe) begin
                        cnt <= cnt_inc;
                        if (last_strobe) begin
                            cnt <= '0;
                            if (state == S_WFILL) begin
                                state <= S_WDRAIN;
                            end else begin
                                state     <= S_RESP;
                                resp_done <= 1'b1;
                                resp_err  <= E_OK;
                                resp_res  <= op_res;
                            end
                        end
                    end
`ifdef L3_EP_TIMEOUT_EN
                    else if (wdog == TO_LIM) begin
                        state     <= S_RESP;
                        resp_done <= 1'b0;
                        resp_err  <= E_TIMEOUT;
                        resp_res  <= op_res;
                    end
`endif
                end
                S_WDRAIN: begin
                    // Extra cycle at cnt==n lets the last read word land in chk_sum
                    if (cnt == n) begin
                        state     <= S_RESP;
                        cnt       <= '0;
                        resp_done <= 1'b1;
                        resp_err  <= E_OK;
                        resp_res  <= op_res;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_RFILL: begin
                    if (cnt_inc == n) begin
                        state <= S_RDRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l3_core_ep.sv
// Self-checking bench for l3_core_ep: vector table, hand sequences and randomized transactions
// checked against a transaction-level model of the endpoint.
module tb_l3_core_ep;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    typedef struct {
        string       tag;
        logic [7:0]  op;
        logic [15:0] ws;
        logic [15:0] ext;
        bit          seq;
        logic [1:0]  err;
    } vec_t;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic clr_core = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    l3_core_ep_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    l3_core_ep #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_core (clr_core),
        .bus      (bus)
    );

    // Write buffer as the endpoint sees it: registered read, one-cycle latency
    logic [31:0] wbuf [0:15];
    always @(posedge clk) if (bus.wb_rd_en) bus.wb_rd_d <= wbuf[bus.wb_rd_addr[3:0]];

    int unsigned wb_q[$];
    int unsigned rba_q[$];
    logic [31:0] rb_q[$];
    int          resp_cnt;
    bit          open_seen;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.resp_rdy) resp_cnt++;
            if (bus.wb_rd_en) wb_q.push_back(32'(bus.wb_rd_addr));
            if (bus.rb_wr_en) begin
                rb_q.push_back(bus.rb_wr_d);
                rba_q.push_back(32'(bus.rb_wr_addr));
            end
            if (bus.wr_open || bus.rd_open || bus.wb_rd_en || bus.rb_wr_en) open_seen = 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: error code from the command rules
    function automatic logic [1:0] model_err(input logic [7:0] op, input logic [15:0] ws,
                                             input logic [15:0] ext);
        int cnt;
        if (op != 8'h01 && op != 8'h02) return 2'b01;
        cnt = (op == 8'h02) ? int'(ext) : int'(ws);
        if (cnt == 0 || cnt > (1 << ADDR_W)) return 2'b10;
        return 2'b00;
    endfunction

    // Waits for cmd_rdy, then presents one command; returns at the negedge after the accept edge
    task automatic issue(input logic [7:0] op, input logic [15:0] ws, input logic [15:0] ext);
        int w;
        w = 0;
        while (!bus.cmd_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("cmd_rdy_before_issue", bus.cmd_rdy, 1);
        bus.cmd_en     = 1'b1;
        bus.cmd_op     = op;
        bus.wr_size    = ws;
        bus.cmd_extend = ext;
        @(negedge clk);
        bus.cmd_en = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic [7:0] op, input logic [15:0] ws,
                           input logic [15:0] ext, input bit seq, input logic [1:0] exp_err);
        int          n, wr_done, rd_done, gap, cyc;
        logic [31:0] sum;
        logic [15:0] iv;
        bit          got;
        n = (op == 8'h02) ? int'(ext) : int'(ws);
        @(negedge clk);
        wb_q.delete();
        rb_q.delete();
        rba_q.delete();
        resp_cnt  = 0;
        open_seen = 1'b0;
        sum = '0;
        issue(op, ws, ext);
        cyc = 1; wr_done = 0; rd_done = 0; gap = 0; got = 1'b0;
        while (!got && cyc < 400) begin
            bus.buf_wr_en = 1'b0;
            bus.buf_rd_en = 1'b0;
            if (bus.resp_rdy) begin
                got = 1'b1;
            end else begin
                if (bus.wr_open && wr_done < n) begin
                    if (gap >= 3 || $urandom_range(2) != 0) begin
                        bus.buf_wr_en  = 1'b1;
                        wbuf[wr_done] = seq ? 32'(wr_done + 1) : $urandom;
                        sum           = sum + wbuf[wr_done];
                        wr_done++;
                        gap = 0;
                    end else gap++;
                end else if (bus.rd_open && rd_done < n) begin
                    if (gap >= 3 || $urandom_range(2) != 0) begin
                        bus.buf_rd_en = 1'b1;
                        rd_done++;
                        gap = 0;
                    end else gap++;
                end else if ($urandom_range(3) == 0) begin
                    // Stray strobes while the buffers are closed must be ignored
                    bus.buf_wr_en = 1'b1;
                    bus.buf_rd_en = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus.buf_wr_en = 1'b0;
        bus.buf_rd_en = 1'b0;
        check({tag, "_resp_seen"}, got, 1);
        check({tag, "_resp_err"}, bus.resp_err, exp_err);
        check({tag, "_resp_done"}, bus.resp_done, (exp_err == 2'b00));
        check({tag, "_resp_res"}, bus.resp_res, op[3:0]);
        check({tag, "_chk_sum"}, bus.chk_sum, (op == 8'h01 && exp_err == 2'b00) ? sum : 32'h0);
        if (exp_err != 2'b00) begin
            check({tag, "_no_buffer_activity"}, open_seen, 0);
            if (exp_err == 2'b01) check({tag, "_resp_latency_le2"}, (cyc <= 2), 1);
        end else if (op == 8'h01) begin
            check({tag, "_wb_reads"}, wb_q.size(), n);
            check({tag, "_rb_writes_none"}, rb_q.size(), 0);
            for (int i = 0; i < wb_q.size(); i++) check({tag, "_wb_addr"}, wb_q[i], i);
        end else begin
            check({tag, "_rb_writes"}, rb_q.size(), n);
            check({tag, "_wb_reads_none"}, wb_q.size(), 0);
            check({tag, "_rd_strobes"}, rd_done, n);
            for (int i = 0; i < rb_q.size(); i++) begin
                iv = 16'(i);
                check({tag, "_rb_addr"}, rba_q[i], i);
                check({tag, "_rb_data"}, rb_q[i], {iv, ~iv});
            end
        end
        @(negedge clk);
        @(negedge clk);
        check({tag, "_resp_one_pulse"}, resp_cnt, 1);
        check({tag, "_resp_done_hold"}, bus.resp_done, (exp_err == 2'b00));
        check({tag, "_resp_err_hold"}, bus.resp_err, exp_err);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, required finish before 1ms");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t        tbl [10];
        logic [7:0]  r_op;
        logic [15:0] r_cnt, r_ws, r_ext;
        int          k;

        bus.cmd_en     = 1'b0;
        bus.cmd_op     = '0;
        bus.cmd_extend = '0;
        bus.wr_size    = '0;
        bus.buf_wr_en  = 1'b0;
        bus.buf_rd_en  = 1'b0;
        for (int i = 0; i < 16; i++) wbuf[i] = '0;

        tbl[0] = '{"write4",    8'h01, 16'd4,      16'd0,      1'b1, 2'b00};
        tbl[1] = '{"read3",     8'h02, 16'd0,      16'd3,      1'b0, 2'b00};
        tbl[2] = '{"badop7f",   8'h7F, 16'd4,      16'd4,      1'b0, 2'b01};
        tbl[3] = '{"wsize0",    8'h01, 16'd0,      16'd5,      1'b0, 2'b10};
        tbl[4] = '{"ext4001",   8'h02, 16'd2,      16'h4001,   1'b0, 2'b10};
        tbl[5] = '{"op00",      8'h00, 16'd1,      16'd1,      1'b0, 2'b01};
        tbl[6] = '{"write1",    8'h01, 16'd1,      16'd0,      1'b0, 2'b00};
        tbl[7] = '{"read1",     8'h02, 16'd0,      16'd1,      1'b0, 2'b00};
        tbl[8] = '{"op82",      8'h82, 16'd1,      16'd1,      1'b0, 2'b01};
        tbl[9] = '{"wsizeffff", 8'h01, 16'hFFFF,   16'd1,      1'b0, 2'b10};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ctrl", {bus.cmd_rdy, bus.wr_open, bus.rd_open, bus.wb_rd_en, bus.rb_wr_en,
                             bus.resp_rdy, bus.resp_done, bus.resp_err, bus.resp_res}, 0);
        check("reset_data", {bus.chk_sum, bus.rb_wr_d}, 0);
        check("reset_addr", {bus.wb_rd_addr, bus.rb_wr_addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_rdy", bus.cmd_rdy, 1);

        for (int i = 0; i < 10; i++)
            run_txn(tbl[i].tag, tbl[i].op, tbl[i].ws, tbl[i].ext, tbl[i].seq, tbl[i].err);

        // Abort during WFILL after 2 of 4 strobes
        issue(8'h01, 16'd4, 16'd0);
        resp_cnt = 0;
        bus.buf_wr_en = 1'b1;
        @(negedge clk);
        bus.buf_wr_en = 1'b1;
        @(negedge clk);
        bus.buf_wr_en = 1'b0;
        clr_core = 1'b1;
        @(negedge clk);
        clr_core = 1'b0;
        check("clr_wfill_wr_open", bus.wr_open, 0);
        check("clr_wfill_cmd_rdy", bus.cmd_rdy, 1);
        repeat (4) @(negedge clk);
        check("clr_wfill_no_resp", resp_cnt, 0);
        run_txn("after_clr_write1", 8'h01, 16'd1, 16'd0, 1'b0, 2'b00);

        // Abort during WDRAIN: chk_sum keeps the words already accumulated
        issue(8'h01, 16'd3, 16'd0);
        resp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            wbuf[i] = 32'(5 + i);
            bus.buf_wr_en = 1'b1;
            @(negedge clk);
        end
        bus.buf_wr_en = 1'b0;
        k = 0;
        while (!bus.wb_rd_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("wdrain_started", bus.wb_rd_en, 1);
        @(negedge clk);
        @(negedge clk);
        clr_core = 1'b1;
        @(negedge clk);
        clr_core = 1'b0;
        check("clr_wdrain_chk_hold", bus.chk_sum, 32'd5);
        check("clr_wdrain_rd_en", bus.wb_rd_en, 0);
        repeat (3) @(negedge clk);
        check("clr_wdrain_chk_hold2", bus.chk_sum, 32'd5);
        check("clr_wdrain_no_resp", resp_cnt, 0);

        // Channel stalls in WFILL after 1 of 2 strobes
        issue(8'h01, 16'd2, 16'd0);
        resp_cnt = 0;
        bus.buf_wr_en = 1'b1;
        @(negedge clk);
        bus.buf_wr_en = 1'b0;
`ifdef L3_EP_TIMEOUT_EN
        k = 0;
        while (bus.wr_open && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("timeout_idle_cycles", k, 16);
        check("timeout_resp_rdy", bus.resp_rdy, 1);
        check("timeout_err", bus.resp_err, 2'b11);
        check("timeout_done", bus.resp_done, 0);
        check("timeout_res", bus.resp_res, 4'h1);
        @(negedge clk);
`else
        repeat (40) @(negedge clk);
        check("stall_wr_open", bus.wr_open, 1);
        check("stall_no_resp", resp_cnt, 0);
        clr_core = 1'b1;
        @(negedge clk);
        clr_core = 1'b0;
        check("stall_clr_cmd_rdy", bus.cmd_rdy, 1);
`endif

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            k = $urandom_range(9);
            r_op = (k < 4) ? 8'h01 : (k < 8) ? 8'h02 : (k == 8) ? 8'($urandom) : 8'h00;
            k = $urandom_range(15);
            r_cnt = (k == 0) ? 16'd0 : (k == 1) ? (($urandom_range(1) == 0) ? 16'h4001 : 16'hFFFF)
                                               : 16'($urandom_range(12, 1));
            r_ws  = (r_op == 8'h02) ? 16'($urandom_range(12)) : r_cnt;
            r_ext = (r_op == 8'h02) ? r_cnt : 16'($urandom_range(12));
            run_txn($sformatf("rnd%0d", t), r_op, r_ws, r_ext, 1'b0, model_err(r_op, r_ws, r_ext));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
